// File: rtl/control_pkg.sv
// Shared constants for the MIPS instruction decoder: opcodes, funct codes,
// ALU encodings and the bit positions of the packed control word.
package control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_JMP   = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd54;
  localparam logic [5:0] OP_SW    = 6'd55;

  localparam logic [5:0] FUNCT_ADD  = 6'd32;
  localparam logic [5:0] FUNCT_SUB  = 6'd34;
  localparam logic [5:0] FUNCT_AND  = 6'd36;
  localparam logic [5:0] FUNCT_OR   = 6'd37;
  localparam logic [5:0] FUNCT_MULT = 6'd24;

  typedef logic [1:0] alu_op_t;

  localparam alu_op_t ALU_ADD = 2'b00;
  localparam alu_op_t ALU_SUB = 2'b01;
  localparam alu_op_t ALU_AND = 2'b10;
  localparam alu_op_t ALU_OR  = 2'b11;

  localparam int unsigned RS_LSB    = 27;
  localparam int unsigned RT_LSB    = 22;
  localparam int unsigned RD_LSB    = 17;
  localparam int unsigned WR_BIT    = 16;
  localparam int unsigned IMM_BIT   = 15;
  localparam int unsigned ALU_LSB   = 13;
  localparam int unsigned MUL_BIT   = 12;
  localparam int unsigned MUX2_BIT  = 11;
  localparam int unsigned MEMWR_BIT = 10;
  localparam int unsigned WB2_BIT   = 9;
  localparam int unsigned BR_BIT    = 8;
  localparam int unsigned JMP_BIT   = 7;

endpackage

// File: rtl/control_decode.sv
// Purely combinational instruction word to packed control word decode.
// Unrecognised opcodes and R-type functs decode to an all-zero word (NOP).
module control_decode
  import control_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [31:0] ctrl_o
);

  logic [5:0] opcode;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [5:0] funct;
  logic       unused_shamt;

  assign opcode       = instr_i[31:26];
  assign rs           = instr_i[25:21];
  assign rt           = instr_i[20:16];
  assign rd           = instr_i[15:11];
  assign funct        = instr_i[5:0];
  assign unused_shamt = ^instr_i[10:6];

  logic    funct_ok;
  alu_op_t r_alu;
  logic    r_mul;

  always_comb begin
    funct_ok = 1'b1;
    r_alu    = ALU_ADD;
    r_mul    = 1'b0;
    case (funct)
      FUNCT_ADD:  r_alu = ALU_ADD;
      FUNCT_SUB:  r_alu = ALU_SUB;
      FUNCT_AND:  r_alu = ALU_AND;
      FUNCT_OR:   r_alu = ALU_OR;
      FUNCT_MULT: r_mul = 1'b1;
      default:    funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    ctrl_o = '0;
    case (opcode)
      OP_RTYPE: begin
        if (funct_ok) begin
          ctrl_o[RS_LSB +: 5]  = rs;
          ctrl_o[RT_LSB +: 5]  = rt;
          ctrl_o[RD_LSB +: 5]  = rd;
          ctrl_o[WR_BIT]       = 1'b1;
          ctrl_o[ALU_LSB +: 2] = r_alu;
          ctrl_o[MUL_BIT]      = r_mul;
          ctrl_o[MUX2_BIT]     = 1'b1;
          ctrl_o[WB2_BIT]      = 1'b1;
        end
      end
      OP_LW: begin
        ctrl_o[RS_LSB +: 5] = rs;
        ctrl_o[RT_LSB +: 5] = rt;
        ctrl_o[RD_LSB +: 5] = rt;
        ctrl_o[WR_BIT]      = 1'b1;
        ctrl_o[IMM_BIT]     = 1'b1;
        ctrl_o[MUX2_BIT]    = 1'b1;
      end
      OP_SW: begin
        // Stores never write the register file; rd mirrors rs.
        ctrl_o[RS_LSB +: 5] = rs;
        ctrl_o[RT_LSB +: 5] = rt;
        ctrl_o[RD_LSB +: 5] = rs;
        ctrl_o[IMM_BIT]     = 1'b1;
        ctrl_o[MUX2_BIT]    = 1'b1;
        ctrl_o[MEMWR_BIT]   = 1'b1;
      end
      OP_ADDI: begin
        ctrl_o[RS_LSB +: 5] = rs;
        ctrl_o[RT_LSB +: 5] = rt;
        ctrl_o[RD_LSB +: 5] = rt;
        ctrl_o[WR_BIT]      = 1'b1;
        ctrl_o[IMM_BIT]     = 1'b1;
        ctrl_o[MUX2_BIT]    = 1'b1;
        ctrl_o[WB2_BIT]     = 1'b1;
      end
      OP_BEQ: begin
        ctrl_o[RS_LSB +: 5]  = rs;
        ctrl_o[RT_LSB +: 5]  = rt;
        ctrl_o[ALU_LSB +: 2] = ALU_SUB;
        ctrl_o[MUX2_BIT]     = 1'b1;
        ctrl_o[BR_BIT]       = 1'b1;
      end
      OP_JMP: begin
        ctrl_o[MUX2_BIT] = 1'b1;
        ctrl_o[JMP_BIT]  = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/control.sv
// Registered instruction decoder: one instruction in per clock, its control
// word out one cycle later. Synchronous active-high reset clears the word.
module control
  import control_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_data,
  output logic [31:0] output_data
);

  logic [31:0] ctrl_d;
  logic [31:0] ctrl_q;

  control_decode u_decode (
    .instr_i (input_data),
    .ctrl_o  (ctrl_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign output_data = ctrl_q;

endmodule

// File: tb/tb_control.sv
// Self-checking bench for control: directed vectors plus randomized
// instructions and resets compared against a behavioural decode model.
module tb_control;

  logic        clk;
  logic        rst;
  logic [31:0] input_data;
  logic [31:0] output_data;

  int unsigned n_vectors;
  int unsigned n_miscompares;

  control dut (
    .clk         (clk),
    .rst         (rst),
    .input_data  (input_data),
    .output_data (output_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference decode built from field values with plain arithmetic.
  function automatic logic [31:0] ref_model(input logic [31:0] ins);
    int unsigned op, f, rs, rt, rd;
    int unsigned wr, imm, alu, mul, mux2, memwr, wb2, br, jmp;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; f = ins[5:0];
    wr = 0; imm = 0; alu = 0; mul = 0; mux2 = 1; memwr = 0; wb2 = 0; br = 0; jmp = 0;
    case (op)
      0: begin
        wr = 1; wb2 = 1;
        if (f == 32) alu = 0;
        else if (f == 34) alu = 1;
        else if (f == 36) alu = 2;
        else if (f == 37) alu = 3;
        else if (f == 24) mul = 1;
        else return 32'h0;
      end
      54: begin rd = rt; wr = 1; imm = 1; end
      55: begin rd = rs; imm = 1; memwr = 1; end
      8:  begin rd = rt; wr = 1; imm = 1; wb2 = 1; end
      4:  begin rd = 0; alu = 1; br = 1; end
      2:  begin rs = 0; rt = 0; rd = 0; jmp = 1; end
      default: return 32'h0;
    endcase
    return rs * 134217728 + rt * 4194304 + rd * 131072 + wr * 65536 + imm * 32768
         + alu * 8192 + mul * 4096 + mux2 * 2048 + memwr * 1024 + wb2 * 512
         + br * 256 + jmp * 128;
  endfunction

  // Present one instruction for one edge and check the registered result.
  task automatic step(input string tag, input logic [31:0] ins, input logic r,
                      input logic [31:0] exp);
    @(negedge clk);
    input_data = ins;
    rst        = r;
    @(posedge clk);
    #1;
    check(tag, output_data, exp);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [5:0]  ops [6];
    logic [5:0]  fns [5];
    ops = '{6'd0, 6'd2, 6'd4, 6'd8, 6'd54, 6'd55};
    fns = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd24};
    ins = $urandom;
    case ($urandom_range(0, 7))
      0, 1, 2, 3, 4, 5: ins[31:26] = ops[$urandom_range(0, 5)];
      6: ins[31:26] = 6'($urandom);
      default: ins[31:26] = 6'd0;
    endcase
    if (ins[31:26] == 6'd0 && $urandom_range(0, 4) != 0) ins[5:0] = fns[$urandom_range(0, 4)];
    return ins;
  endfunction

  initial begin
    logic [31:0] ins;
    logic        r;
    n_vectors     = 0;
    n_miscompares = 0;
    rst           = 1'b1;
    input_data    = 32'h0;

    step("reset", 32'hD822_0004, 1'b1, 32'h0000_0000);
    step("lw",    32'hD822_0004, 1'b0, 32'h0885_8800);
    step("sw",    32'hDC64_0004, 1'b0, 32'h1906_8C00);
    step("jmp",   32'h0800_0004, 1'b0, 32'h0000_0880);
    step("add",   32'h00A6_3820, 1'b0, 32'h298F_0A00);
    step("beq",   32'h10A6_0003, 1'b0, 32'h2980_2900);
    step("op63",  32'hFC22_0004, 1'b0, 32'h0000_0000);
    step("funct0", 32'h00A6_3800, 1'b0, 32'h0000_0000);
    step("sub",   32'h00A6_3822, 1'b0, 32'h298F_2A00);
    step("mult",  32'h00A6_3818, 1'b0, 32'h298F_1A00);
    step("addi",  32'h20A6_FFFF, 1'b0, 32'h298D_8A00);
    step("rst_mid", 32'hD822_0004, 1'b1, 32'h0000_0000);
    step("post_rst", 32'hD822_0004, 1'b0, 32'h0885_8800);

    for (int i = 0; i < 400; i++) begin
      ins = rand_instr();
      r   = ($urandom_range(0, 15) == 0);
      step(r ? "rand_rst" : "rand", ins, r, r ? 32'h0 : ref_model(ins));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
